counter_add_sched: RTL and testbench

Sequencer and two-port arbiter for the team's mod-100 byte adder (two-digit 0–99 datapath, results above 99 wrap). Two requesters each ask for a step value to be accumulated a given number of times. The block round-robins between them, runs the repeated additions on one internal adder instance into a shared 0–99 accumulator, and reports completion. It sits between the front-panel/counter control logic and the adder datapath.

---
 rtl/counter_add_sched.sv | 145 ++++++++++++++
 tb/tb_counter_add_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_add_sched.sv
// ============================================================================
//  Module      : counter_add_sched
//  Description : Round-robin sequencer for two requesters sharing one mod-100
//                adder that repeatedly accumulates into a 0-99 accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_add_sched (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] step0,
    input  logic [7:0] step1,
    input  logic [3:0] cnt0,
    input  logic [3:0] cnt1,
    input  logic       clr,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic       err,
    output logic       wrap,
    output logic [7:0] acc
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] c_mod     = 8'd100;
    localparam logic [7:0] c_max_val = 8'd99;

    logic [1:0] r_state;
    logic [7:0] r_acc;
    logic [1:0] r_gnt;
    logic       r_busy;
    logic       r_done;
    logic       r_done_id;
    logic       r_err;
    logic       r_wrap;
    logic       r_last_id;
    logic       r_id;
    logic [7:0] r_step;
    logic [3:0] r_rem;

    logic       w_sel_id;
    logic [7:0] w_sel_step;
    logic [3:0] w_sel_cnt;
    logic [7:0] w_raw;
    logic       w_wrap;
    logic [7:0] w_next_acc;

    // On contention, the requester not served last time wins.
    always_comb begin
        if (req0 && req1) begin
            w_sel_id = ~r_last_id;
        end else begin
            w_sel_id = req1;
        end
    end

    assign w_sel_step = w_sel_id ? step1 : step0;
    assign w_sel_cnt  = w_sel_id ? cnt1  : cnt0;

    // Operands never exceed 99, so the raw sum (max 198) fits in 8 bits.
    assign w_raw      = r_acc + r_step;
    assign w_wrap     = (w_raw > c_max_val);
    assign w_next_acc = w_wrap ? (w_raw - c_mod) : w_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_acc     <= 8'd0;
            r_gnt     <= 2'b00;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= 1'b0;
            r_err     <= 1'b0;
            r_wrap    <= 1'b0;
            r_last_id <= 1'b1;
            r_id      <= 1'b0;
            r_step    <= 8'd0;
            r_rem     <= 4'd0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_wrap <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clr) begin
                        r_acc <= 8'd0;
                    end else if (req0 || req1) begin
                        r_id      <= w_sel_id;
                        r_last_id <= w_sel_id;
                        r_step    <= w_sel_step;
                        r_rem     <= w_sel_cnt;
                        r_busy    <= 1'b1;
                        if (w_sel_step > c_max_val || w_sel_cnt == 4'd0) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_done_id <= w_sel_id;
                            r_err     <= (w_sel_step > c_max_val);
                        end else begin
                            r_state <= S_RUN;
                            r_gnt   <= w_sel_id ? 2'b10 : 2'b01;
                        end
                    end
                end
                S_RUN: begin
                    r_acc  <= w_next_acc;
                    r_wrap <= w_wrap;
                    r_rem  <= r_rem - 4'd1;
                    if (r_rem == 4'd1) begin
                        r_state   <= S_DONE;
                        r_gnt     <= 2'b00;
                        r_done    <= 1'b1;
                        r_done_id <= r_id;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign err     = r_err;
    assign wrap    = r_wrap;
    assign acc     = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_counter_add_sched.sv
// ============================================================================
//  Module      : tb_counter_add_sched
//  Description : Directed self-checking bench for counter_add_sched.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_add_sched;

    logic       clk;
    logic       rst_n;
    logic       req0;
    logic       req1;
    logic [7:0] step0;
    logic [7:0] step1;
    logic [3:0] cnt0;
    logic [3:0] cnt1;
    logic       clr;
    logic [1:0] gnt;
    logic       busy;
    logic       done;
    logic       done_id;
    logic       err;
    logic       wrap;
    logic [7:0] acc;

    int         r_checks;
    int         r_passed;
    logic [7:0] r_model_acc;

    counter_add_sched u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .step0   (step0),
        .step1   (step1),
        .cnt0    (cnt0),
        .cnt1    (cnt1),
        .clr     (clr),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .err     (err),
        .wrap    (wrap),
        .acc     (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        r_checks++;
        if (actual === expected) begin
            r_passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full legal operation (cnt >= 1); expected acc/wrap come from a mod-100 model.
    task automatic run_op(input logic id, input logic [7:0] step, input logic [3:0] cnt);
        logic [8:0] raw;
        if (id) begin
            req1 = 1'b1; step1 = step; cnt1 = cnt;
        end else begin
            req0 = 1'b1; step0 = step; cnt0 = cnt;
        end
        tick();
        check("op_gnt", gnt, id ? 2'b10 : 2'b01);
        check("op_busy", busy, 1'b1);
        for (int i = 1; i <= int'(cnt); i++) begin
            raw = {1'b0, r_model_acc} + {1'b0, step};
            r_model_acc = (raw > 9'd99) ? 8'(raw - 9'd100) : raw[7:0];
            tick();
            check("op_acc", acc, r_model_acc);
            if (i < int'(cnt)) begin
                check("op_wrap", wrap, (raw > 9'd99));
                check("op_gnt_run", gnt, id ? 2'b10 : 2'b01);
                check("op_no_done", done, 1'b0);
            end else begin
                check("op_done", done, 1'b1);
                check("op_done_id", done_id, id);
                check("op_err", err, 1'b0);
                check("op_gnt_done", gnt, 2'b00);
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        check("op_idle_busy", busy, 1'b0);
        check("op_idle_done", done, 1'b0);
    endtask

    initial begin
        r_checks = 0; r_passed = 0; r_model_acc = 8'd0;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; clr = 1'b0;
        step0 = 8'd0; step1 = 8'd0; cnt0 = 4'd0; cnt1 = 4'd0;
        tick();
        tick();
        check("rst_acc", acc, 8'd0);
        check("rst_gnt", gnt, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_done_id", done_id, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_wrap", wrap, 1'b0);
        rst_n = 1'b1;
        tick();

        // Basic 7 x 3, then bring acc to 95 and do 3 x 4 across the wrap.
        run_op(1'b0, 8'd7, 4'd3);
        check("t1_acc21", acc, 8'd21);
        run_op(1'b0, 8'd74, 4'd1);
        check("t2_acc95", acc, 8'd95);
        run_op(1'b1, 8'd3, 4'd4);
        check("t2_acc7", acc, 8'd7);

        // Both requesters held: grants alternate starting with 0 (last served was 1).
        req0 = 1'b1; req1 = 1'b1; step0 = 8'd1; step1 = 8'd1; cnt0 = 4'd1; cnt1 = 4'd1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rr_gnt", gnt, (k % 2) ? 2'b10 : 2'b01);
            tick();
            check("rr_done", done, 1'b1);
            check("rr_done_id", done_id, (k % 2) ? 1'b1 : 1'b0);
            if (k == 3) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            tick();
            check("rr_idle", busy, 1'b0);
        end
        check("rr_acc11", acc, 8'd11);
        r_model_acc = 8'd11;

        // Illegal step: immediate done with err, acc untouched.
        req0 = 1'b1; step0 = 8'd100; cnt0 = 4'd5;
        tick();
        check("ill_done", done, 1'b1);
        check("ill_err", err, 1'b1);
        check("ill_gnt", gnt, 2'b00);
        check("ill_acc", acc, 8'd11);
        req0 = 1'b0;
        tick();
        check("ill_idle", busy, 1'b0);

        // Zero count: immediate done without err.
        req1 = 1'b1; step1 = 8'd5; cnt1 = 4'd0;
        tick();
        check("z_done", done, 1'b1);
        check("z_err", err, 1'b0);
        check("z_done_id", done_id, 1'b1);
        check("z_acc", acc, 8'd11);
        req1 = 1'b0;
        tick();

        // clr beats a simultaneous request; request served next cycle.
        clr = 1'b1; req0 = 1'b1; step0 = 8'd2; cnt0 = 4'd1;
        tick();
        check("clr_acc", acc, 8'd0);
        check("clr_gnt", gnt, 2'b00);
        check("clr_busy", busy, 1'b0);
        clr = 1'b0;
        tick();
        check("clr_gnt_next", gnt, 2'b01);
        tick();
        check("clr_done", done, 1'b1);
        check("clr_acc2", acc, 8'd2);
        req0 = 1'b0;
        tick();

        // Reset during the 2nd add of a cnt=5 op by requester 1.
        req1 = 1'b1; step1 = 8'd3; cnt1 = 4'd5;
        tick();
        tick();
        check("ra_acc5", acc, 8'd5);
        #2;
        rst_n = 1'b0;
        req1 = 1'b0;
        #1;
        check("ra_acc0", acc, 8'd0);
        check("ra_gnt", gnt, 2'b00);
        check("ra_busy", busy, 1'b0);
        check("ra_done", done, 1'b0);
        tick();
        check("ra_done_hold", done, 1'b0);
        tick();
        rst_n = 1'b1;
        req0 = 1'b1; req1 = 1'b1; step0 = 8'd1; cnt0 = 4'd1; step1 = 8'd5; cnt1 = 4'd1;
        tick();
        check("ra_first_gnt", gnt, 2'b01);
        req1 = 1'b0;
        tick();
        check("ra_first_done_id", done_id, 1'b0);
        check("ra_first_acc", acc, 8'd1);
        req0 = 1'b0;
        tick();
        r_model_acc = 8'd1;

        // Boundary arithmetic: 98+1, 99+1, 99+99, step 0.
        run_op(1'b0, 8'd97, 4'd1);
        check("b_acc98", acc, 8'd98);
        run_op(1'b1, 8'd1, 4'd3);
        check("b_acc1", acc, 8'd1);
        run_op(1'b0, 8'd98, 4'd1);
        check("b_acc99", acc, 8'd99);
        run_op(1'b1, 8'd99, 4'd2);
        check("b_acc97", acc, 8'd97);
        run_op(1'b0, 8'd0, 4'd2);
        check("b_acc97_zero", acc, 8'd97);

        $display("%0d/%0d checks passed", r_passed, r_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
